// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory, redirect and issue signals of the fetch unit
interface fetch_unit_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   // Instruction memory request/response
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [ILEN-1:0] imem_rdata;

   // Control-flow redirect from the execute stage
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   // Held instruction towards decode
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [ILEN-1:0] out_instruction;
   logic            out_is_add;
   logic            out_fault;
   logic [XLEN-1:0] out_count;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rdata,
      input  redirect_valid, redirect_pc,
      output out_valid, out_pc, out_instruction, out_is_add, out_fault, out_count,
      input  out_ready
   );

   // Memory / pipeline side
   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rdata,
      output redirect_valid, redirect_pc,
      input  out_valid, out_pc, out_instruction, out_is_add, out_fault, out_count,
      output out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-entry instruction fetch stage with redirect and fault handling
module fetch_unit #(
   parameter int              XLEN         = 32,
   parameter int              ILEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic           clock,
   input  logic           reset,
   fetch_unit_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
   localparam logic [XLEN-1:0] CNT_STEP = XLEN'(1);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] held_pc;
   logic [ILEN-1:0] held_instr;
   logic [XLEN-1:0] count;

   // A redirect target must be word aligned; anything else traps into FAULT
   logic redirect_aligned;
   assign redirect_aligned = (bus.redirect_pc[1:0] == 2'b00);

   // Fetch sequencer: redirect wins over memory response and downstream accept
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= RESET_VECTOR;
         held_pc    <= '0;
         held_instr <= '0;
         count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Redirects are ignored until the first fetch is issued
               state <= FETCH;
            end

            FETCH: begin
               if (bus.redirect_valid) begin
                  // Any response arriving with the redirect belongs to the old path
                  if (redirect_aligned) begin
                     pc    <= bus.redirect_pc;
                     state <= FETCH;
                  end else begin
                     state <= FAULT;
                  end
               end else if (bus.imem_ready) begin
                  held_instr <= bus.imem_rdata;
                  held_pc    <= pc;
                  pc         <= pc + PC_STEP;
                  state      <= FULL;
               end
            end

            FULL: begin
               if (bus.redirect_valid) begin
                  // Held instruction is squashed and never counted
                  if (redirect_aligned) begin
                     pc    <= bus.redirect_pc;
                     state <= FETCH;
                  end else begin
                     state <= FAULT;
                  end
               end else if (bus.out_ready) begin
                  count <= count + CNT_STEP;
                  state <= FETCH;
               end
            end

            FAULT: begin
               // Only an aligned redirect (or reset) recovers
               if (bus.redirect_valid && redirect_aligned) begin
                  pc    <= bus.redirect_pc;
                  state <= FETCH;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from the state and data registers
   assign bus.imem_req        = (state == FETCH);
   assign bus.imem_addr       = pc;
   assign bus.out_valid       = (state == FULL);
   assign bus.out_fault       = (state == FAULT);
   assign bus.out_pc          = held_pc;
   assign bus.out_instruction = held_instr;
   assign bus.out_count       = count;

   // RV32 ADD: OP opcode with funct3 and funct7 both zero
   assign bus.out_is_add = (state == FULL)
                         && (held_instr[6:0]   == 7'b0110011)
                         && (held_instr[14:12] == 3'b000)
                         && (held_instr[31:25] == 7'b0000000);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - vector table, reset sequences and random model check of fetch_unit
module tb_fetch_unit;

   logic clock;
   logic reset;

   fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

   fetch_unit #(.XLEN(32), .ILEN(32), .RESET_VECTOR(32'h0)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        ready;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        oready;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] opc;
      logic [31:0] instr;
      logic        add;
      logic        fault;
      logic [31:0] cnt;
   } vec_t;

   vec_t vt[23];

   // Reference model: plain description of what the fetch stage holds
   bit          m_idle, m_fault, m_full;
   logic [31:0] m_pc, m_opc, m_ins, m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] opc, input logic [31:0] instr,
                            input logic add, input logic fault, input logic [31:0] cnt);
      check({tag, ".imem_req"},  {31'b0, bus.imem_req},   {31'b0, req});
      check({tag, ".imem_addr"}, bus.imem_addr,           addr);
      check({tag, ".out_valid"}, {31'b0, bus.out_valid},  {31'b0, valid});
      check({tag, ".out_pc"},    bus.out_pc,              opc);
      check({tag, ".out_instr"}, bus.out_instruction,     instr);
      check({tag, ".out_is_add"},{31'b0, bus.out_is_add}, {31'b0, add});
      check({tag, ".out_fault"}, {31'b0, bus.out_fault},  {31'b0, fault});
      check({tag, ".out_count"}, bus.out_count,           cnt);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic ready, input logic [31:0] rdata, input logic redir,
                        input logic [31:0] rpc, input logic oready);
      bus.imem_ready     = ready;
      bus.imem_rdata     = rdata;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.out_ready      = oready;
   endtask

   function automatic bit is_add(input logic [31:0] w);
      return (w[6:0] == 7'h33) && (w[14:12] == 3'd0) && (w[31:25] == 7'd0);
   endfunction

   task automatic model_reset();
      m_idle = 1; m_fault = 0; m_full = 0;
      m_pc = 32'h0; m_opc = 32'h0; m_ins = 32'h0; m_cnt = 32'h0;
   endtask

   task automatic model_edge(input logic ready, input logic [31:0] rdata, input logic redir,
                             input logic [31:0] rpc, input logic oready);
      if (m_idle) begin
         m_idle = 0;
      end else if (redir) begin
         m_full = 0;
         if (rpc % 4 == 0) begin
            m_pc    = rpc;
            m_fault = 0;
         end else begin
            m_fault = 1;
         end
      end else if (m_fault) begin
         // stuck until an aligned redirect
      end else if (m_full) begin
         if (oready) begin
            m_cnt  = m_cnt + 1;
            m_full = 0;
         end
      end else if (ready) begin
         m_ins  = rdata;
         m_opc  = m_pc;
         m_pc   = m_pc + 4;
         m_full = 1;
      end
   endtask

   task automatic model_check(input string tag);
      check_all(tag, !m_idle && !m_fault && !m_full, m_pc, m_full, m_opc, m_ins,
                m_full && is_add(m_ins), m_fault, m_cnt);
   endtask

   initial begin
      logic        r_ready, r_redir, r_oready;
      logic [31:0] r_rdata, r_rpc;
      int          sel;

      vt[0]  = '{1'b1, 32'h002081B3, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'd0};
      vt[1]  = '{1'b1, 32'h002081B3, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        1'b1, 32'h0,        32'h002081B3, 1'b1, 1'b0, 32'd0};
      vt[2]  = '{1'b1, 32'h402081B3, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        32'h002081B3, 1'b0, 1'b0, 32'd1};
      vt[3]  = '{1'b1, 32'h402081B3, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8,        1'b1, 32'h4,        32'h402081B3, 1'b0, 1'b0, 32'd1};
      vt[4]  = '{1'b1, 32'h402081B3, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b0, 32'h4,        32'h402081B3, 1'b0, 1'b0, 32'd2};
      vt[5]  = '{1'b1, 32'h11111111, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        1'b1, 32'h8,        32'h11111111, 1'b0, 1'b0, 32'd2};
      vt[6]  = '{1'b1, 32'h11111111, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        1'b0, 32'h8,        32'h11111111, 1'b0, 1'b0, 32'd3};
      vt[7]  = '{1'b1, 32'h22222222, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 32'hC,        32'h22222222, 1'b0, 1'b0, 32'd3};
      vt[8]  = '{1'b1, 32'h33333333, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 32'hC,        32'h22222222, 1'b0, 1'b0, 32'd3};
      vt[9]  = '{1'b1, 32'h33333333, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 32'hC,        32'h22222222, 1'b0, 1'b0, 32'd3};
      vt[10] = '{1'b1, 32'h33333333, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 32'hC,        32'h22222222, 1'b0, 1'b0, 32'd3};
      vt[11] = '{1'b1, 32'h33333333, 1'b1, 32'h100,      1'b1, 1'b1, 32'h100,      1'b0, 32'hC,        32'h22222222, 1'b0, 1'b0, 32'd3};
      vt[12] = '{1'b1, 32'h44444444, 1'b0, 32'h0,        1'b0, 1'b0, 32'h104,      1'b1, 32'h100,      32'h44444444, 1'b0, 1'b0, 32'd3};
      vt[13] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      1'b0, 32'h100,      32'h44444444, 1'b0, 1'b0, 32'd4};
      vt[14] = '{1'b1, 32'h55555555, 1'b1, 32'h200,      1'b0, 1'b1, 32'h200,      1'b0, 32'h100,      32'h44444444, 1'b0, 1'b0, 32'd4};
      vt[15] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b0, 32'h100,      32'h44444444, 1'b0, 1'b0, 32'd4};
      vt[16] = '{1'b0, 32'h0,        1'b1, 32'h102,      1'b0, 1'b0, 32'h200,      1'b0, 32'h100,      32'h44444444, 1'b0, 1'b1, 32'd4};
      vt[17] = '{1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h200,      1'b0, 32'h100,      32'h44444444, 1'b0, 1'b1, 32'd4};
      vt[18] = '{1'b0, 32'h0,        1'b1, 32'h103,      1'b0, 1'b0, 32'h200,      1'b0, 32'h100,      32'h44444444, 1'b0, 1'b1, 32'd4};
      vt[19] = '{1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 1'b1, 32'h200,      1'b0, 32'h100,      32'h44444444, 1'b0, 1'b0, 32'd4};
      vt[20] = '{1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h100,      32'h44444444, 1'b0, 1'b0, 32'd4};
      vt[21] = '{1'b1, 32'h66666666, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h66666666, 1'b0, 1'b0, 32'd4};
      vt[22] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'hFFFFFFFC, 32'h66666666, 1'b0, 1'b0, 32'd5};

      // Reset state
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      reset = 1'b0;
      #3;
      check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      step();
      step();
      reset = 1'b1;

      // Directed vector table
      for (int i = 0; i < 23; i++) begin
         drive(vt[i].ready, vt[i].rdata, vt[i].redir, vt[i].rpc, vt[i].oready);
         step();
         check_all($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].valid, vt[i].opc,
                   vt[i].instr, vt[i].add, vt[i].fault, vt[i].cnt);
      end

      // Reset in FULL with out_ready already high: aborts, count cleared
      drive(1'b1, 32'h002081B3, 1'b0, 32'h0, 1'b0);
      step();
      check_all("pre_rst_full", 1'b0, 32'h4, 1'b1, 32'h0, 32'h002081B3, 1'b1, 1'b0, 32'd5);
      drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check_all("rst_full_now", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      step();
      check_all("rst_full_edge", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

      // Redirect during IDLE is ignored
      drive(1'b1, 32'h77777777, 1'b1, 32'h300, 1'b0);
      reset = 1'b1;
      step();
      check_all("idle_redir", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      drive(1'b1, 32'h88888888, 1'b0, 32'h0, 1'b1);
      step();
      check_all("after_idle", 1'b0, 32'h4, 1'b1, 32'h0, 32'h88888888, 1'b0, 1'b0, 32'd0);
      step();
      check_all("accept1", 1'b1, 32'h4, 1'b0, 32'h0, 32'h88888888, 1'b0, 1'b0, 32'd1);

      // Reset while a response is arriving in FETCH: response ignored
      drive(1'b1, 32'h99999999, 1'b0, 32'h0, 1'b1);
      reset = 1'b0;
      #1;
      check_all("rst_fetch_now", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      step();
      check_all("rst_fetch_edge", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      reset = 1'b1;

      // Randomized run against the reference model
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 249) == 0) begin
            drive(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
            reset = 1'b0;
            #1;
            model_reset();
            model_check($sformatf("rnd_rst%0d", c));
            step();
            reset = 1'b1;
            continue;
         end
         r_ready  = ($urandom_range(0, 1) == 1);
         r_oready = ($urandom_range(0, 2) != 0);
         r_redir  = ($urandom_range(0, 7) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 6)       r_rpc = $urandom & 32'h0000_0FFC;
         else if (sel == 6) r_rpc = 32'hFFFF_FFF8;
         else               r_rpc = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
         sel = $urandom_range(0, 3);
         if (sel == 0)      r_rdata = {7'd0, 5'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h33};
         else if (sel == 1) r_rdata = {7'h20, 5'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h33};
         else               r_rdata = $urandom;
         drive(r_ready, r_rdata, r_redir, r_rpc, r_oready);
         model_edge(r_ready, r_rdata, r_redir, r_rpc, r_oready);
         step();
         model_check($sformatf("rnd%0d", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
